// File: rtl/fisr_fp_pkg.sv
// Shared definitions for the FISR floating-point stream datapath:
// bias/pattern helpers, exception flag indices and operand classes.
package fisr_fp_pkg;

  // Bit positions inside the 3-bit {nv, of, uf} flag vector
  localparam int FLG_NV = 2;
  localparam int FLG_OF = 1;
  localparam int FLG_UF = 0;

  typedef enum logic [1:0] {
    ZERO = 2'd0,   // zero or denormal (denormals are flushed)
    NORM = 2'd1,
    INF  = 2'd2,
    NAN  = 2'd3
  } fp_class_t;

  // Exponent bias for an EXP_W-bit exponent field
  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Positive infinity, right-aligned in 64 bits; caller truncates to W
  function automatic logic [63:0] fp_inf_bits(input int exp_w, input int man_w);
    return ((64'd1 << exp_w) - 64'd1) << man_w;
  endfunction

  // Canonical quiet NaN: sign 0, exponent all ones, mantissa MSB set
  function automatic logic [63:0] fp_qnan_bits(input int exp_w, input int man_w);
    return fp_inf_bits(exp_w, man_w) | (64'd1 << (man_w - 1));
  endfunction

endpackage

// File: rtl/fp_mul_round.sv
// Combinational normalise + round + post-round carry fix-up for the
// stage-2 product. Rounding mode selected by FP_MUL_RNE_EN:
//   defined   -> round-to-nearest-even (guard/round/sticky)
//   undefined -> truncation toward zero
module fp_mul_round
  import fisr_fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic signed [EXP_W+1:0]   i_e,
  input  logic        [2*MAN_W+1:0] i_m,
  output logic signed [EXP_W+1:0]   o_e,
  output logic        [MAN_W-1:0]   o_frac
);

  localparam int EW = EXP_W + 2;
  localparam int MW = 2 * MAN_W + 2;

  logic                 w_hi;
  logic [MAN_W-1:0]     w_frac;
  logic                 w_g;
  logic                 w_r;
  logic                 w_st;
  logic                 w_inc;
  logic [MAN_W+1:0]     w_sum;
  logic signed [EW-1:0] w_e_n;

  // Normalise: product of two 1.x values lies in [1,4); if bit MW-1 is set
  // the value is in [2,4), so take the fraction one bit higher and bump e.
  always_comb begin
    w_hi = i_m[MW-1];
    if (w_hi) begin
      w_frac = i_m[2*MAN_W -: MAN_W];
      w_g    = i_m[MAN_W];
      w_r    = i_m[MAN_W-1];
      w_st   = |i_m[MAN_W-2:0];
      w_e_n  = i_e + $signed(EW'(1));
    end else begin
      w_frac = i_m[2*MAN_W-1 -: MAN_W];
      w_g    = i_m[MAN_W-1];
      w_r    = i_m[MAN_W-2];
      w_st   = |i_m[MAN_W-3:0];
      w_e_n  = i_e;
    end
  end

`ifdef FP_MUL_RNE_EN
  // Round up above half, or at exactly half when the lsb is odd
  assign w_inc = w_g & (w_r | w_st | w_frac[0]);
`else
  // Truncation discards the bits below the lsb
  assign w_inc = 1'b0;
  logic w_unused_grs;
  assign w_unused_grs = w_g | w_r | w_st;
`endif

  // Hidden one kept so an all-ones fraction carries into bit MAN_W+1
  assign w_sum = {2'b01, w_frac} + (MAN_W+2)'(w_inc);

  // Post-round carry: mantissa wrapped to 10.00..0, renormalise and bump e
  always_comb begin
    if (w_sum[MAN_W+1]) begin
      o_e    = w_e_n + $signed(EW'(1));
      o_frac = w_sum[MAN_W:1];
    end else begin
      o_e    = w_e_n;
      o_frac = w_sum[MAN_W-1:0];
    end
  end

endmodule

// File: rtl/fp_mul_stream.sv
// Pipelined IEEE-754 multiplier with valid/ready handshake and sideband tag.
// Stage 1 unpacks/multiplies/classifies, stage 2 normalises, rounds and packs,
// stages 3..STAGES are delay registers. A single enable (in_ready) stalls
// every stage together, so bubbles travel with the data.
// Rounding mode macro: FP_MUL_RNE_EN (see fp_mul_round).
// rst_n is expected to be released synchronously by the system reset logic.
module fp_mul_stream
  import fisr_fp_pkg::*;
#(
  parameter int EXP_W  = 8,
  parameter int MAN_W  = 23,
  parameter int TAG_W  = 32,
  parameter int STAGES = 3    // legal 2..6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   in_a,
  input  logic [EXP_W+MAN_W:0]   in_b,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_p,
  output logic [TAG_W-1:0]       out_tag,
  output logic [2:0]             out_flags
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int EW = EXP_W + 2;
  localparam int MW = 2 * MAN_W + 2;

  localparam logic [W-1:0]         P_INF  = W'(fp_inf_bits(EXP_W, MAN_W));
  localparam logic [W-1:0]         P_QNAN = W'(fp_qnan_bits(EXP_W, MAN_W));
  localparam logic signed [EW-1:0] E_BIAS = EW'(fp_bias(EXP_W));
  localparam logic signed [EW-1:0] E_MAX  = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] E_ZERO = '0;

  function automatic fp_class_t classify(input logic [EXP_W-1:0] e,
                                         input logic [MAN_W-1:0] m);
    if (&e)            return (|m) ? NAN : INF;
    else if (e == '0)  return ZERO;
    else               return NORM;
  endfunction

  logic w_en;

  // ---------------- stage 1: unpack, exponent sum, mantissa product
  logic [EXP_W-1:0]     w_ea, w_eb;
  logic [MAN_W-1:0]     w_ma, w_mb;
  logic signed [EW-1:0] w_e1;
  logic [MW-1:0]        w_m1;

  assign w_ea = in_a[W-2 -: EXP_W];
  assign w_eb = in_b[W-2 -: EXP_W];
  assign w_ma = in_a[MAN_W-1:0];
  assign w_mb = in_b[MAN_W-1:0];
  assign w_e1 = $signed({2'b00, w_ea}) + $signed({2'b00, w_eb}) - E_BIAS;
  assign w_m1 = MW'({1'b1, w_ma}) * MW'({1'b1, w_mb});

  logic                 r1_s;
  logic signed [EW-1:0] r1_e;
  logic [MW-1:0]        r1_m;
  fp_class_t            r1_ca, r1_cb;
  logic [TAG_W-1:0]     r1_tag;

  // Stage-1 operand registers, held while the pipeline is stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_s   <= 1'b0;
      r1_e   <= '0;
      r1_m   <= '0;
      r1_ca  <= ZERO;
      r1_cb  <= ZERO;
      r1_tag <= '0;
    end else if (w_en) begin
      r1_s   <= in_a[W-1] ^ in_b[W-1];
      r1_e   <= w_e1;
      r1_m   <= w_m1;
      r1_ca  <= classify(w_ea, w_ma);
      r1_cb  <= classify(w_eb, w_mb);
      r1_tag <= in_tag;
    end
  end

  // ---------------- stage 2: normalise, round, pack, specials
  logic signed [EW-1:0] w_e2;
  logic [MAN_W-1:0]     w_frac2;
  logic [W-1:0]         w_p2;
  logic [2:0]           w_flg2;

  fp_mul_round #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_round (
    .i_e    (r1_e),
    .i_m    (r1_m),
    .o_e    (w_e2),
    .o_frac (w_frac2)
  );

  // Special-operand priority: NaN/Inf*0, Inf, zero, overflow, underflow
  always_comb begin
    w_p2   = {r1_s, w_e2[EXP_W-1:0], w_frac2};
    w_flg2 = 3'b000;
    if (r1_ca == NAN || r1_cb == NAN ||
        (r1_ca == INF && r1_cb == ZERO) || (r1_ca == ZERO && r1_cb == INF)) begin
      w_p2           = P_QNAN;
      w_flg2[FLG_NV] = 1'b1;
    end else if (r1_ca == INF || r1_cb == INF) begin
      w_p2 = {r1_s, P_INF[W-2:0]};
    end else if (r1_ca == ZERO || r1_cb == ZERO) begin
      w_p2 = {r1_s, {(W-1){1'b0}}};
    end else if (w_e2 >= E_MAX) begin
      w_p2           = {r1_s, P_INF[W-2:0]};
      w_flg2[FLG_OF] = 1'b1;
    end else if (w_e2 <= E_ZERO) begin
      w_p2           = {r1_s, {(W-1){1'b0}}};
      w_flg2[FLG_UF] = 1'b1;
    end
  end

  // ---------------- stages 2..STAGES: result registers and delay line
  logic [STAGES:1]              r_vld_pipe;
  logic [STAGES:2][W-1:0]       r_p_pipe;
  logic [STAGES:2][TAG_W-1:0]   r_tag_pipe;
  logic [STAGES:2][2:0]         r_flg_pipe;

  // Valid shift register plus result/tag/flag delay line, all on one enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_pipe <= '0;
      r_p_pipe   <= '0;
      r_tag_pipe <= '0;
      r_flg_pipe <= '0;
    end else if (w_en) begin
      r_vld_pipe    <= {r_vld_pipe[STAGES-1:1], in_valid};
      r_p_pipe[2]   <= w_p2;
      r_tag_pipe[2] <= r1_tag;
      r_flg_pipe[2] <= w_flg2;
      for (int k = 3; k <= STAGES; k++) begin
        r_p_pipe[k]   <= r_p_pipe[k-1];
        r_tag_pipe[k] <= r_tag_pipe[k-1];
        r_flg_pipe[k] <= r_flg_pipe[k-1];
      end
    end
  end

  assign out_valid = r_vld_pipe[STAGES];
  assign out_p     = r_p_pipe[STAGES];
  assign out_tag   = r_tag_pipe[STAGES];
  assign out_flags = r_flg_pipe[STAGES];

  // Advance only when the output slot is empty or being drained
  assign in_ready = !out_valid || out_ready;
  assign w_en     = in_ready;

endmodule

// File: tb/tb_fp_mul_stream.sv
// Directed self-checking bench for fp_mul_stream (STAGES = 3, binary32).
// Expected round-sensitive result follows FP_MUL_RNE_EN.
module tb_fp_mul_stream;

  localparam int STAGES = 3;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a, in_b, in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_p, out_tag;
  logic [2:0]  out_flags;

  int n_checks = 0;
  int n_fail   = 0;

  fp_mul_stream #(
    .EXP_W  (8),
    .MAN_W  (23),
    .TAG_W  (32),
    .STAGES (STAGES)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .out_tag   (out_tag),
    .out_flags (out_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Drive one operand pair, wait (bounded) for its result; out_ready assumed 1
  task automatic send_one(input logic [31:0] a, input logic [31:0] b, input logic [31:0] tag,
                          output logic [31:0] p, output logic [31:0] tg,
                          output logic [2:0] flg, output int lat);
    @(negedge clk);
    in_valid = 1'b1; in_a = a; in_b = b; in_tag = tag;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    p = out_p; tg = out_tag; flg = out_flags;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++; if (out_p !== 32'h0) begin n_fail++; $display("FAIL reset_out_p: got %h want 0", out_p); end
    n_checks++; if (out_tag !== 32'h0) begin n_fail++; $display("FAIL reset_out_tag: got %h want 0", out_tag); end
    n_checks++; if (out_flags !== 3'b000) begin n_fail++; $display("FAIL reset_out_flags: got %b want 000", out_flags); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    logic [31:0] p, tg; logic [2:0] f; int lat;
    send_one(32'h40000000, 32'h40400000, 32'h00000011, p, tg, f, lat);
    n_checks++; if (lat !== STAGES) begin n_fail++; $display("FAIL basic_latency: got %0d want %0d", lat, STAGES); end
    n_checks++; if (p !== 32'h40C00000) begin n_fail++; $display("FAIL basic_p: got %h want 40c00000", p); end
    n_checks++; if (f !== 3'b000) begin n_fail++; $display("FAIL basic_flags: got %b want 000", f); end
    n_checks++; if (tg !== 32'h00000011) begin n_fail++; $display("FAIL basic_tag: got %h want 00000011", tg); end
  endtask

  task automatic test_sign_tag();
    logic [31:0] p, tg; logic [2:0] f; int lat;
    send_one(32'h3FC00000, 32'hBFC00000, 32'hDEADBEEF, p, tg, f, lat);
    n_checks++; if (lat !== STAGES) begin n_fail++; $display("FAIL sign_latency: got %0d want %0d", lat, STAGES); end
    n_checks++; if (p !== 32'hC0100000) begin n_fail++; $display("FAIL sign_p: got %h want c0100000", p); end
    n_checks++; if (tg !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sign_tag: got %h want deadbeef", tg); end
  endtask

  task automatic test_rounding();
    logic [31:0] p, tg; logic [2:0] f; int lat; logic [31:0] want;
`ifdef FP_MUL_RNE_EN
    want = 32'h3FC00002;
`else
    want = 32'h3FC00001;
`endif
    send_one(32'h3FC00000, 32'h3F800001, 32'h0, p, tg, f, lat);
    n_checks++; if (p !== want) begin n_fail++; $display("FAIL round_tie_p: got %h want %h", p, want); end
    n_checks++; if (f !== 3'b000) begin n_fail++; $display("FAIL round_tie_flags: got %b want 000", f); end
  endtask

  task automatic test_specials();
    logic [31:0] ta [10] = '{32'h7F800000, 32'h7F000000, 32'h00800000, 32'h7FC12345, 32'hFF800000,
                             32'h80000000, 32'h00000001, 32'h7F000000, 32'h00800000, 32'h00800000};
    logic [31:0] tb [10] = '{32'h00000000, 32'h7F000000, 32'h00800000, 32'h3F800000, 32'h40000000,
                             32'h40000000, 32'h40000000, 32'h40000000, 32'h3F800000, 32'h3F000000};
    logic [31:0] tp [10] = '{32'h7FC00000, 32'h7F800000, 32'h00000000, 32'h7FC00000, 32'hFF800000,
                             32'h80000000, 32'h00000000, 32'h7F800000, 32'h00800000, 32'h00000000};
    logic [2:0]  tf [10] = '{3'b100, 3'b010, 3'b001, 3'b100, 3'b000,
                             3'b000, 3'b000, 3'b010, 3'b000, 3'b001};
    logic [31:0] p, tg; logic [2:0] f; int lat;
    for (int i = 0; i < 10; i++) begin
      send_one(ta[i], tb[i], 32'h1000 + i, p, tg, f, lat);
      n_checks++; if (p !== tp[i]) begin n_fail++; $display("FAIL special_p[%0d]: got %h want %h", i, p, tp[i]); end
      n_checks++; if (f !== tf[i]) begin n_fail++; $display("FAIL special_flags[%0d]: got %b want %b", i, f, tf[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a_tab [8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                               32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
    logic [31:0] e_tab [8] = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000,
                               32'h41200000, 32'h41400000, 32'h41600000, 32'h41800000};
    int sent = 0, rcv = 0, cyc = 0, stall_seen = 0, extra = 0;
    logic stalled_prev = 1'b0;
    logic [31:0] held_p = '0, held_tag = '0;
    while (rcv < 8 && cyc < 100) begin
      @(negedge clk);
      out_ready = !(cyc >= 6 && cyc < 11);
      if (sent < 8) begin
        in_valid = 1'b1; in_a = a_tab[sent]; in_b = 32'h40000000; in_tag = sent;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (stalled_prev) begin
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_hold_valid: got %b want 1", out_valid); end
        n_checks++; if (out_p !== held_p) begin n_fail++; $display("FAIL b2b_hold_p: got %h want %h", out_p, held_p); end
        n_checks++; if (out_tag !== held_tag) begin n_fail++; $display("FAIL b2b_hold_tag: got %h want %h", out_tag, held_tag); end
      end
      if (!out_ready && out_valid) begin
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_stall_in_ready: got %b want 0", in_ready); end
        held_p = out_p; held_tag = out_tag; stalled_prev = 1'b1; stall_seen++;
      end else begin
        stalled_prev = 1'b0;
      end
      if (out_valid && out_ready) begin
        n_checks++; if (out_p !== e_tab[rcv]) begin n_fail++; $display("FAIL b2b_p[%0d]: got %h want %h", rcv, out_p, e_tab[rcv]); end
        n_checks++; if (out_tag !== rcv) begin n_fail++; $display("FAIL b2b_tag[%0d]: got %h want %h", rcv, out_tag, rcv); end
        rcv++;
      end
      if (in_valid && in_ready) sent++;
      cyc++;
    end
    n_checks++; if (rcv !== 8) begin n_fail++; $display("FAIL b2b_count: got %0d want 8", rcv); end
    n_checks++; if (stall_seen !== 5) begin n_fail++; $display("FAIL b2b_stall_cycles: got %0d want 5", stall_seen); end
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) extra++;
      @(negedge clk);
    end
    n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL b2b_extra_results: got %0d want 0", extra); end
  endtask

  task automatic test_reset_midstream();
    logic [31:0] p, tg; logic [2:0] f; int lat; int extra = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_a = 32'h40000000; in_b = 32'h40000000; in_tag = 32'h100 + i;
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_valid: got %b want 1", out_valid); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_async_valid: got %b want 0", out_valid); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send_one(32'h40400000, 32'h40400000, 32'h00000055, p, tg, f, lat);
    n_checks++; if (lat !== STAGES) begin n_fail++; $display("FAIL midrst_latency: got %0d want %0d", lat, STAGES); end
    n_checks++; if (tg !== 32'h00000055) begin n_fail++; $display("FAIL midrst_tag: got %h want 00000055", tg); end
    n_checks++; if (p !== 32'h41100000) begin n_fail++; $display("FAIL midrst_p: got %h want 41100000", p); end
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      if (out_valid) extra++;
      @(negedge clk);
    end
    n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL midrst_stale_results: got %0d want 0", extra); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sign_tag();
    test_rounding();
    test_specials();
    test_back_to_back();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
